// File: rtl/ysyx_22050854_divider_pkg.sv
// Shared definitions for the iterative radix-2 restoring divider.
// Contents: FSM state enum, operand width, iteration counts and a
// 32-to-XLEN sign-extension helper used for the W-form results.
package ysyx_22050854_divider_pkg;

  localparam int XLEN = 64;
  localparam int HLEN = XLEN / 2;

  localparam logic [6:0] DIV64_ITER = 7'd64;
  localparam logic [6:0] DIV32_ITER = 7'd32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Sign-extend the low half of a word to the full width
  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    return {{HLEN{v[HLEN-1]}}, v[HLEN-1:0]};
  endfunction

endpackage

// File: rtl/ysyx_22050854_divider_if.sv
// Handshake bundle between the EXU (master) and the divider (slave).
// master drives: div_valid, flush, divw, div_signed, dividend, divisor
// slave drives : div_ready, div_doing, out_valid, quotient, remainder
interface ysyx_22050854_divider_if;
  import ysyx_22050854_divider_pkg::*;

  logic            div_valid;
  logic            flush;
  logic            divw;
  logic            div_signed;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            div_ready;
  logic            div_doing;
  logic            out_valid;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport master (
    output div_valid, flush, divw, div_signed, dividend, divisor,
    input  div_ready, div_doing, out_valid, quotient, remainder
  );

  modport slave (
    input  div_valid, flush, divw, div_signed, dividend, divisor,
    output div_ready, div_doing, out_valid, quotient, remainder
  );

endinterface

// File: rtl/ysyx_22050854_div_signfix.sv
// Conditional two's-complement negate, XLEN wide (combinational).
// Ports: neg  - 1 selects -din, 0 passes din through
//        din  - input value
//        dout - result
module ysyx_22050854_div_signfix
  import ysyx_22050854_divider_pkg::*;
(
  input  logic            neg,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] dout
);

  assign dout = neg ? (~din + {{(XLEN-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/ysyx_22050854_divider.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the
// W forms. One quotient bit per cycle on operand magnitudes, sign applied
// at the end; divide-by-zero and signed overflow finish without iterating.
// Ports: clock - clock, all state on posedge
//        reset - synchronous active-high reset
//        bus   - slave side of ysyx_22050854_divider_if (valid/ready/flush,
//                op selects, operands, out_valid pulse and results)
// Build option: DIV_EARLY_EXIT_EN - finish at accept when |dividend| < |divisor|.
module ysyx_22050854_divider
  import ysyx_22050854_divider_pkg::*;
(
  input logic                    clock,
  input logic                    reset,
  ysyx_22050854_divider_if.slave bus
);

  div_state_e      state_r;
  logic [6:0]      cnt_r;
  logic [XLEN-1:0] rem_r, quo_r, dvs_r;
  logic            divw_r, q_neg_r, r_neg_r;
  logic            ready_r, doing_r, out_valid_r;
  logic [XLEN-1:0] quotient_r, remainder_r;

  logic [XLEN-1:0] dvd_ext_s, dvs_ext_s, min_s, raw_dvd_s;
  logic [XLEN-1:0] dvd_abs_s, dvs_abs_s;
  logic            sa_s, sb_s, dvs_zero_s, ovf_s;
  logic [XLEN:0]   rem_sh_s, diff_s;
  logic            ge_s;
  logic [XLEN-1:0] rem_nx_s, quo_nx_s, qfix_s, rfix_s;

  // Extend the operands of the selected width to XLEN (sign or zero)
  always_comb begin
    if (bus.divw) begin
      if (bus.div_signed) begin
        dvd_ext_s = sext32(bus.dividend);
        dvs_ext_s = sext32(bus.divisor);
      end else begin
        dvd_ext_s = {{HLEN{1'b0}}, bus.dividend[HLEN-1:0]};
        dvs_ext_s = {{HLEN{1'b0}}, bus.divisor[HLEN-1:0]};
      end
      min_s     = {{(HLEN+1){1'b1}}, {(HLEN-1){1'b0}}};
      raw_dvd_s = sext32(bus.dividend);
    end else begin
      dvd_ext_s = bus.dividend;
      dvs_ext_s = bus.divisor;
      min_s     = {1'b1, {(XLEN-1){1'b0}}};
      raw_dvd_s = bus.dividend;
    end
  end

  // After extension the top bit is the operand sign for either width
  assign sa_s       = bus.div_signed & dvd_ext_s[XLEN-1];
  assign sb_s       = bus.div_signed & dvs_ext_s[XLEN-1];
  assign dvs_zero_s = (dvs_ext_s == {XLEN{1'b0}});
  assign ovf_s      = bus.div_signed & (dvd_ext_s == min_s) & (&dvs_ext_s);

  ysyx_22050854_div_signfix u_abs_dvd (.neg(sa_s), .din(dvd_ext_s), .dout(dvd_abs_s));
  ysyx_22050854_div_signfix u_abs_dvs (.neg(sb_s), .din(dvs_ext_s), .dout(dvs_abs_s));

  // The shifted partial remainder needs one extra bit: divisors above
  // 2^63 can leave 2*rem+1 beyond 64 bits before the subtract.
  assign rem_sh_s = {rem_r, quo_r[XLEN-1]};
  assign diff_s   = rem_sh_s - {1'b0, dvs_r};
  assign ge_s     = ~diff_s[XLEN];
  assign rem_nx_s = ge_s ? diff_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
  assign quo_nx_s = {quo_r[XLEN-2:0], ge_s};

  ysyx_22050854_div_signfix u_fix_q (.neg(q_neg_r), .din(quo_nx_s), .dout(qfix_s));
  ysyx_22050854_div_signfix u_fix_r (.neg(r_neg_r), .din(rem_nx_s), .dout(rfix_s));

  // Divider FSM: accept, iterate, present the one-cycle result
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 7'd0;
      rem_r       <= {XLEN{1'b0}};
      quo_r       <= {XLEN{1'b0}};
      dvs_r       <= {XLEN{1'b0}};
      divw_r      <= 1'b0;
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      ready_r     <= 1'b1;
      doing_r     <= 1'b0;
      out_valid_r <= 1'b0;
      quotient_r  <= {XLEN{1'b0}};
      remainder_r <= {XLEN{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          out_valid_r <= 1'b0;
          quotient_r  <= {XLEN{1'b0}};
          remainder_r <= {XLEN{1'b0}};
          if (bus.div_valid & ~bus.flush) begin
            divw_r  <= bus.divw;
            q_neg_r <= sa_s ^ sb_s;
            r_neg_r <= sa_s;
            ready_r <= 1'b0;
            if (dvs_zero_s) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              quotient_r  <= {XLEN{1'b1}};
              remainder_r <= raw_dvd_s;
            end else if (ovf_s) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              quotient_r  <= dvd_ext_s;
              remainder_r <= {XLEN{1'b0}};
`ifdef DIV_EARLY_EXIT_EN
            end else if (dvd_abs_s < dvs_abs_s) begin
              state_r     <= DONE;
              out_valid_r <= 1'b1;
              quotient_r  <= {XLEN{1'b0}};
              remainder_r <= raw_dvd_s;
`endif
            end else begin
              state_r <= BUSY;
              doing_r <= 1'b1;
              rem_r   <= {XLEN{1'b0}};
              dvs_r   <= dvs_abs_s;
              // W ops start with the 32-bit magnitude in the top half so the
              // same left shift walks through exactly 32 dividend bits.
              if (bus.divw) begin
                quo_r <= {dvd_abs_s[HLEN-1:0], {HLEN{1'b0}}};
                cnt_r <= DIV32_ITER;
              end else begin
                quo_r <= dvd_abs_s;
                cnt_r <= DIV64_ITER;
              end
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (bus.flush) begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            doing_r <= 1'b0;
          end else begin
            rem_r <= rem_nx_s;
            quo_r <= quo_nx_s;
            cnt_r <= cnt_r - 7'd1;
            if (cnt_r == 7'd1) begin
              state_r     <= DONE;
              doing_r     <= 1'b0;
              out_valid_r <= 1'b1;
              quotient_r  <= divw_r ? sext32(qfix_s) : qfix_s;
              remainder_r <= divw_r ? sext32(rfix_s) : rfix_s;
            end else begin
              state_r <= BUSY;
            end
          end
        end
        DONE: begin
          state_r     <= IDLE;
          ready_r     <= 1'b1;
          doing_r     <= 1'b0;
          out_valid_r <= 1'b0;
          quotient_r  <= {XLEN{1'b0}};
          remainder_r <= {XLEN{1'b0}};
        end
        default: begin
          state_r     <= IDLE;
          ready_r     <= 1'b1;
          doing_r     <= 1'b0;
          out_valid_r <= 1'b0;
          quotient_r  <= {XLEN{1'b0}};
          remainder_r <= {XLEN{1'b0}};
        end
      endcase
    end
  end

  assign bus.div_ready = ready_r;
  assign bus.div_doing = doing_r;
  assign bus.out_valid = out_valid_r;
  assign bus.quotient  = quotient_r;
  assign bus.remainder = remainder_r;

endmodule

// File: tb/tb_ysyx_22050854_divider.sv
// Self-checking bench for ysyx_22050854_divider: directed operand vectors,
// an arithmetic reference model pinned by literal expectations, and one
// per-cycle compare process on the result outputs.
module tb_ysyx_22050854_divider;
  import ysyx_22050854_divider_pkg::*;

`ifdef DIV_EARLY_EXIT_EN
  localparam int SMALL_EDGES = 0;
`else
  localparam int SMALL_EDGES = 64;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_cyc = -1;
  logic [63:0] exp_q = 64'd0;
  logic [63:0] exp_r = 64'd0;

  always #5 clock = ~clock;

  // Cycle index: number of rising edges seen so far
  always @(posedge clock) cyc <= cyc + 1;

  ysyx_22050854_divider_if bus();

  ysyx_22050854_divider dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%h expected 0x%h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Reference: RISC-V M-extension results by plain arithmetic, plus the
  // number of iterating edges the op needs (0 for the finish-at-accept cases)
  function automatic void model(input bit w, input bit s, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] q,
                                output logic [63:0] r, output int edges);
    logic [31:0] a32, b32, tq, tr;
    bit spec;
    a32 = a[31:0];
    b32 = b[31:0];
    spec = 1'b0;
    if (w) begin
      if (b32 == 32'd0) begin
        tq = 32'hFFFF_FFFF; tr = a32; spec = 1'b1;
      end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        tq = a32; tr = 32'd0; spec = 1'b1;
      end else if (s) begin
        tq = $signed(a32) / $signed(b32);
        tr = $signed(a32) % $signed(b32);
      end else begin
        tq = a32 / b32;
        tr = a32 % b32;
      end
      q = {{32{tq[31]}}, tq};
      r = {{32{tr[31]}}, tr};
    end else begin
      if (b == 64'd0) begin
        q = 64'hFFFF_FFFF_FFFF_FFFF; r = a; spec = 1'b1;
      end else if (s && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        q = a; r = 64'd0; spec = 1'b1;
      end else if (s) begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end else begin
        q = a / b;
        r = a % b;
      end
    end
    edges = spec ? 0 : (w ? 32 : 64);
`ifdef DIV_EARLY_EXIT_EN
    begin
      logic [63:0] ma, mb;
      if (w) begin
        ma = (s && a32[31]) ? {32'd0, -a32} : {32'd0, a32};
        mb = (s && b32[31]) ? {32'd0, -b32} : {32'd0, b32};
      end else begin
        ma = (s && a[63]) ? -a : a;
        mb = (s && b[63]) ? -b : b;
      end
      if (!spec && ma < mb) edges = 0;
    end
`endif
  endfunction

  // Pin the model to literals, present the op for one accept edge, and
  // return at the first falling edge after acceptance
  task automatic start(input string nm, input bit w, input bit s, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] lq, input logic [63:0] lr,
                       input int ledges);
    logic [63:0] q, r;
    int e;
    model(w, s, a, b, q, r, e);
    check({nm, "_model_q"}, q, lq);
    check({nm, "_model_r"}, r, lr);
    check({nm, "_model_latency"}, 64'(e), 64'(ledges));
    @(negedge clock);
    check({nm, "_ready_before"}, {63'd0, bus.div_ready}, 64'd1);
    bus.div_valid  = 1'b1;
    bus.divw       = w;
    bus.div_signed = s;
    bus.dividend   = a;
    bus.divisor    = b;
    exp_q   = q;
    exp_r   = r;
    exp_cyc = cyc + 1 + e;
    @(negedge clock);
    bus.div_valid = 1'b0;
    bus.dividend  = {$urandom, $urandom};
    bus.divisor   = {$urandom, $urandom};
    if (e > 0) check({nm, "_ready_doing_busy"}, {62'd0, bus.div_ready, bus.div_doing}, 64'd1);
    else       check({nm, "_ready_doing_done"}, {62'd0, bus.div_ready, bus.div_doing}, 64'd0);
  endtask

  task automatic op(input string nm, input bit w, input bit s, input logic [63:0] a,
                    input logic [63:0] b, input logic [63:0] lq, input logic [63:0] lr,
                    input int ledges);
    start(nm, w, s, a, b, lq, lr, ledges);
    while (cyc < exp_cyc) @(negedge clock);
  endtask

  // Per-cycle compare: result pulse exactly in the expected cycle, zeros otherwise
  always @(negedge clock) begin
    if (!reset) begin
      if (cyc == exp_cyc) begin
        check("out_valid_pulse", {63'd0, bus.out_valid}, 64'd1);
        check("quotient", bus.quotient, exp_q);
        check("remainder", bus.remainder, exp_r);
      end else begin
        check("out_valid_quiet", {63'd0, bus.out_valid}, 64'd0);
        check("outputs_zero", bus.quotient | bus.remainder, 64'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit reached, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.div_valid  = 1'b0;
    bus.flush      = 1'b0;
    bus.divw       = 1'b0;
    bus.div_signed = 1'b0;
    bus.dividend   = 64'd0;
    bus.divisor    = 64'd0;
    repeat (2) @(negedge clock);
    check("rst_ready", {63'd0, bus.div_ready}, 64'd1);
    check("rst_doing", {63'd0, bus.div_doing}, 64'd0);
    check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("rst_quotient", bus.quotient, 64'd0);
    check("rst_remainder", bus.remainder, 64'd0);
    reset = 1'b0;

    op("divu_100_7", 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 64);
    op("div_m7_2", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
       64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64);
    op("remw_ovf", 1'b1, 1'b1, 64'hDEAD_BEEF_8000_0000, 64'h1234_5678_FFFF_FFFF,
       64'hFFFF_FFFF_8000_0000, 64'd0, 0);
    op("div_ovf64", 1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
       64'h8000_0000_0000_0000, 64'd0, 0);
    op("divu_5_0", 1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 0);
    op("divuw_5_0", 1'b1, 1'b0, 64'hAAAA_0000_0000_0005, 64'h5555_0000_0000_0000,
       64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 0);
    op("divw_7fff_10", 1'b1, 1'b1, 64'hFFFF_0000_7FFF_FFFF, 64'h1111_2222_0000_0010,
       64'h0000_0000_07FF_FFFF, 64'h0000_0000_0000_000F, 32);
    op("divw_m7_2", 1'b1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'h0000_0000_0000_0002,
       64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 32);
    op("divuw_sext", 1'b1, 1'b0, 64'h1234_5678_FFFF_FFFE, 64'hFFFF_FFFF_0000_0001,
       64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 32);
    op("divuw_8000_3", 1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'd3,
       64'h0000_0000_2AAA_AAAA, 64'd2, 32);
    op("divu_big", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
       64'd1, 64'h7FFF_FFFF_FFFF_FFFE, 64);
    op("divu_3_10", 1'b0, 1'b0, 64'd3, 64'd10, 64'd0, 64'd3, SMALL_EDGES);
    op("div_m3_10", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd10,
       64'd0, 64'hFFFF_FFFF_FFFF_FFFD, SMALL_EDGES);

    // Flush while iterating: no pulse for that op, idle right after
    start("flushed", 1'b0, 1'b0, 64'd1000, 64'd3, 64'd333, 64'd1, 64);
    repeat (9) @(negedge clock);
    bus.flush = 1'b1;
    exp_cyc = -1;
    @(negedge clock);
    bus.flush = 1'b0;
    check("flush_ready", {63'd0, bus.div_ready}, 64'd1);
    check("flush_doing", {63'd0, bus.div_doing}, 64'd0);
    op("after_flush", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
       64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 64);

    // Flush in the result cycle, then flush together with valid in idle
    start("dz_flush", 1'b0, 1'b0, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd9, 0);
    bus.flush     = 1'b1;
    bus.div_valid = 1'b1;
    bus.dividend  = 64'd100;
    bus.divisor   = 64'd7;
    repeat (2) @(negedge clock);
    check("flush_valid_no_accept", {62'd0, bus.div_ready, bus.div_doing}, 64'd2);
    bus.flush     = 1'b0;
    bus.div_valid = 1'b0;

    // Reset mid-operation drops the op
    start("reset_mid", 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 64);
    repeat (4) @(negedge clock);
    reset = 1'b1;
    exp_cyc = -1;
    @(negedge clock);
    check("midrst_ready", {63'd0, bus.div_ready}, 64'd1);
    check("midrst_doing", {63'd0, bus.div_doing}, 64'd0);
    check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("midrst_outputs", bus.quotient | bus.remainder, 64'd0);
    reset = 1'b0;
    op("after_reset", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3,
       64'h5555_5555_5555_5555, 64'd0, 64);

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
